// File: rtl/ysyx_25010008_pkg.sv
// Shared decode encodings for the IDU and EXU: ALU opcodes, next-PC, write-back
// and CSR data selects.
package ysyx_25010008_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned NPC_SEL_W  = 3;
  localparam int unsigned RW_SEL_W   = 3;
  localparam int unsigned OP2_SEL_W  = 2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 8'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 8'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 8'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 8'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 8'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 8'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 8'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 8'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 8'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 8'd9;
  localparam logic [ALU_OP_W-1:0] ALU_EQ     = 8'd10;
  localparam logic [ALU_OP_W-1:0] ALU_NE     = 8'd11;
  localparam logic [ALU_OP_W-1:0] ALU_GE     = 8'd12;
  localparam logic [ALU_OP_W-1:0] ALU_GEU    = 8'd13;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB  = 8'd14;
  localparam logic [ALU_OP_W-1:0] ALU_MUL    = 8'd16;
  localparam logic [ALU_OP_W-1:0] ALU_MULH   = 8'd17;
  localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 8'd18;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 8'd19;
  localparam logic [ALU_OP_W-1:0] ALU_DIV    = 8'd20;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 8'd21;
  localparam logic [ALU_OP_W-1:0] ALU_REM    = 8'd22;
  localparam logic [ALU_OP_W-1:0] ALU_REMU   = 8'd23;

  localparam logic [NPC_SEL_W-1:0] NPC_PC4    = 3'd0;
  localparam logic [NPC_SEL_W-1:0] NPC_JAL    = 3'd1;
  localparam logic [NPC_SEL_W-1:0] NPC_JALR   = 3'd2;
  localparam logic [NPC_SEL_W-1:0] NPC_BRANCH = 3'd3;
  localparam logic [NPC_SEL_W-1:0] NPC_CSR    = 3'd4;

  localparam logic [RW_SEL_W-1:0] RW_ALU   = 3'd0;
  localparam logic [RW_SEL_W-1:0] RW_PC4   = 3'd1;
  localparam logic [RW_SEL_W-1:0] RW_MEM   = 3'd2;
  localparam logic [RW_SEL_W-1:0] RW_IMM   = 3'd3;
  localparam logic [RW_SEL_W-1:0] RW_AUIPC = 3'd4;
  localparam logic [RW_SEL_W-1:0] RW_CSR   = 3'd5;

  localparam logic [OP2_SEL_W-1:0] OP2_SRC2 = 2'd0;
  localparam logic [OP2_SEL_W-1:0] OP2_IMM  = 2'd1;
  localparam logic [OP2_SEL_W-1:0] OP2_CSR  = 2'd2;
  localparam logic [OP2_SEL_W-1:0] OP2_ZERO = 2'd3;

  localparam logic CSR1_SRC1 = 1'b0;
  localparam logic CSR1_SET  = 1'b1;
  localparam logic CSR2_PC   = 1'b0;
  localparam logic CSR2_CAUSE = 1'b1;

  localparam logic [XLEN-1:0] MCAUSE_ECALL_M = 32'd11;

endpackage

// File: rtl/ysyx_25010008_alu.sv
// Combinational RV32 ALU. Define YSYX_25010008_EXU_RV32M_EN to add the M-extension
// multiply/divide opcodes; otherwise those codes return zero.
module ysyx_25010008_alu
  import ysyx_25010008_pkg::*;
(
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic [ALU_OP_W-1:0] opcode,
  output logic [XLEN-1:0]     result
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

`ifdef YSYX_25010008_EXU_RV32M_EN
  logic [2*XLEN-1:0] prod_ss;
  logic [2*XLEN-1:0] prod_su;
  logic [2*XLEN-1:0] prod_uu;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   b_sdiv;
  logic [XLEN-1:0]   b_udiv;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   quot_u;
  logic [XLEN-1:0]   rem_u;

  // Sign/zero-extend to 64 bits so one unsigned multiply yields each high half
  assign prod_ss = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
  assign prod_su = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{1'b0}}, b};
  assign prod_uu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  // Divisor forced to 1 on zero/overflow: keeps the divider defined and gives
  // quotient=a, remainder=0, which is exactly the overflow result
  assign div_zero = (b == '0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_sdiv   = (div_zero || div_ovf) ? 32'd1 : b;
  assign b_udiv   = div_zero ? 32'd1 : b;
  assign quot_s   = $unsigned($signed(a) / $signed(b_sdiv));
  assign rem_s    = $unsigned($signed(a) % $signed(b_sdiv));
  assign quot_u   = a / b_udiv;
  assign rem_u    = a % b_udiv;
`endif

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:   result = {31'd0, lt_s};
      ALU_SLTU:  result = {31'd0, lt_u};
      ALU_EQ:    result = {31'd0, a == b};
      ALU_NE:    result = {31'd0, a != b};
      ALU_GE:    result = {31'd0, ~lt_s};
      ALU_GEU:   result = {31'd0, ~lt_u};
      ALU_PASSB: result = b;
`ifdef YSYX_25010008_EXU_RV32M_EN
      ALU_MUL:    result = prod_uu[XLEN-1:0];
      ALU_MULH:   result = prod_ss[2*XLEN-1:XLEN];
      ALU_MULHSU: result = prod_su[2*XLEN-1:XLEN];
      ALU_MULHU:  result = prod_uu[2*XLEN-1:XLEN];
      ALU_DIV:    result = div_zero ? '1 : quot_s;
      ALU_DIVU:   result = div_zero ? '1 : quot_u;
      ALU_REM:    result = div_zero ? a : rem_s;
      ALU_REMU:   result = div_zero ? a : rem_u;
`endif
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25010008_exu.sv
// Execute unit: combinational ALU, next-PC, GPR and CSR write-back muxing plus a
// one-cycle registered done. YSYX_25010008_EXU_RV32M_EN enables RV32M in the ALU.
module ysyx_25010008_exu
  import ysyx_25010008_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       pc,
  input  logic [NPC_SEL_W-1:0]  npc_sel,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       src1,
  input  logic [XLEN-1:0]       src2,
  input  logic [RW_SEL_W-1:0]   r_wdata_sel,
  input  logic [XLEN-1:0]       csr_src,
  input  logic                  csr_wdata1_sel,
  input  logic                  csr_wdata2_sel,
  input  logic [ALU_OP_W-1:0]   alu_opcode,
  input  logic [OP2_SEL_W-1:0]  alu_operand2_sel,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [XLEN-1:0]       alu_result,
  output logic [XLEN-1:0]       npc,
  output logic [XLEN-1:0]       r_wdata,
  output logic [XLEN-1:0]       csr_wdata1,
  output logic [XLEN-1:0]       csr_wdata2,
  output logic                  done
);

  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_target;

  always_comb begin
    operand_b = '0;
    case (alu_operand2_sel)
      OP2_SRC2: operand_b = src2;
      OP2_IMM:  operand_b = imm;
      OP2_CSR:  operand_b = csr_src;
      default:  operand_b = '0;
    endcase
  end

  ysyx_25010008_alu u_alu (
    .a      (src1),
    .b      (operand_b),
    .opcode (alu_opcode),
    .result (alu_result)
  );

  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_imm = pc + imm;
  assign jalr_target = (src1 + imm) & ~32'd1;

  // Reset overrides only the fetch address; the rest of the datapath stays live
  always_comb begin
    npc = pc_plus4;
    if (!rst) begin
      npc = RESET_PC;
    end else begin
      case (npc_sel)
        NPC_JAL:    npc = pc_plus_imm;
        NPC_JALR:   npc = jalr_target;
        NPC_BRANCH: npc = alu_result[0] ? pc_plus_imm : pc_plus4;
        NPC_CSR:    npc = csr_src;
        default:    npc = pc_plus4;
      endcase
    end
  end

  always_comb begin
    r_wdata = '0;
    case (r_wdata_sel)
      RW_ALU:   r_wdata = alu_result;
      RW_PC4:   r_wdata = pc_plus4;
      RW_MEM:   r_wdata = mem_rdata;
      RW_IMM:   r_wdata = imm;
      RW_AUIPC: r_wdata = pc_plus_imm;
      RW_CSR:   r_wdata = csr_src;
      default:  r_wdata = '0;
    endcase
  end

  assign csr_wdata1 = (csr_wdata1_sel == CSR1_SET)   ? (csr_src | src1) : src1;
  assign csr_wdata2 = (csr_wdata2_sel == CSR2_CAUSE) ? MCAUSE_ECALL_M   : pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= in_valid;
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_exu.sv
// Table-driven bench for ysyx_25010008_exu with a scoreboard for the registered done.
module tb_ysyx_25010008_exu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] pc;
  logic [2:0]  npc_sel;
  logic [31:0] imm;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [2:0]  r_wdata_sel;
  logic [31:0] csr_src;
  logic        csr_wdata1_sel;
  logic        csr_wdata2_sel;
  logic [7:0]  alu_opcode;
  logic [1:0]  alu_operand2_sel;
  logic [31:0] mem_rdata;
  logic [31:0] alu_result;
  logic [31:0] npc;
  logic [31:0] r_wdata;
  logic [31:0] csr_wdata1;
  logic [31:0] csr_wdata2;
  logic        done;

  ysyx_25010008_exu dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .pc               (pc),
    .npc_sel          (npc_sel),
    .imm              (imm),
    .src1             (src1),
    .src2             (src2),
    .r_wdata_sel      (r_wdata_sel),
    .csr_src          (csr_src),
    .csr_wdata1_sel   (csr_wdata1_sel),
    .csr_wdata2_sel   (csr_wdata2_sel),
    .alu_opcode       (alu_opcode),
    .alu_operand2_sel (alu_operand2_sel),
    .mem_rdata        (mem_rdata),
    .alu_result       (alu_result),
    .npc              (npc),
    .r_wdata          (r_wdata),
    .csr_wdata1       (csr_wdata1),
    .csr_wdata2       (csr_wdata2),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] M_ALU = 5'b00001;
  localparam logic [4:0] M_NPC = 5'b00010;
  localparam logic [4:0] M_RW  = 5'b00100;
  localparam logic [4:0] M_C1  = 5'b01000;
  localparam logic [4:0] M_C2  = 5'b10000;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] pc;
    logic [2:0]  nsel;
    logic [31:0] imm;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [2:0]  rsel;
    logic [31:0] csr;
    logic        c1sel;
    logic        c2sel;
    logic [7:0]  op;
    logic [1:0]  o2;
    logic [31:0] mem;
    logic [4:0]  mask;
    logic [31:0] e_alu;
    logic [31:0] e_npc;
    logic [31:0] e_rw;
    logic [31:0] e_c1;
    logic [31:0] e_c2;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t blank(input string n);
    vec_t t;
    t.name = n; t.v = 1'b1; t.pc = 32'h8000_0000; t.nsel = 3'd0; t.imm = '0;
    t.s1 = '0; t.s2 = '0; t.rsel = 3'd0; t.csr = '0; t.c1sel = 1'b0; t.c2sel = 1'b0;
    t.op = 8'd0; t.o2 = 2'd0; t.mem = '0; t.mask = '0;
    t.e_alu = '0; t.e_npc = '0; t.e_rw = '0; t.e_c1 = '0; t.e_c2 = '0;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    in_valid = t.v; pc = t.pc; npc_sel = t.nsel; imm = t.imm; src1 = t.s1; src2 = t.s2;
    r_wdata_sel = t.rsel; csr_src = t.csr; csr_wdata1_sel = t.c1sel;
    csr_wdata2_sel = t.c2sel; alu_opcode = t.op; alu_operand2_sel = t.o2; mem_rdata = t.mem;
  endtask

  // One cycle: retire the pending done expectation, drive, then check comb outputs
  task automatic step(input vec_t t);
    vec_t e;
    @(posedge clk); #1;
    if (done_q.size() > 0) chk({"done after ", t.name}, {31'd0, done}, {31'd0, done_q.pop_front()});
    drive(t);
    exp_q.push_back(t);
    done_q.push_back(t.v);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.mask[0]) chk({e.name, " alu_result"}, alu_result, e.e_alu);
    if (e.mask[1]) chk({e.name, " npc"},        npc,        e.e_npc);
    if (e.mask[2]) chk({e.name, " r_wdata"},    r_wdata,    e.e_rw);
    if (e.mask[3]) chk({e.name, " csr_wdata1"}, csr_wdata1, e.e_c1);
    if (e.mask[4]) chk({e.name, " csr_wdata2"}, csr_wdata2, e.e_c2);
  endtask

  initial begin
    vec_t t;

    t = blank("add_imm"); t.s1 = 5; t.imm = 32'hFFFF_FFFD; t.o2 = 1; t.op = 0;
    t.mask = M_ALU | M_NPC | M_RW; t.e_alu = 2; t.e_npc = 32'h8000_0004; t.e_rw = 2; vecs.push_back(t);
    t = blank("blt_taken"); t.pc = 32'h8000_0010; t.imm = 32'h20; t.op = 8; t.nsel = 3;
    t.s1 = 32'hFFFF_FFFF; t.s2 = 1; t.mask = M_ALU | M_NPC; t.e_alu = 1; t.e_npc = 32'h8000_0030; vecs.push_back(t);
    t = blank("blt_not"); t.pc = 32'h8000_0010; t.imm = 32'h20; t.op = 8; t.nsel = 3;
    t.s1 = 1; t.s2 = 32'hFFFF_FFFF; t.mask = M_ALU | M_NPC; t.e_alu = 0; t.e_npc = 32'h8000_0014; vecs.push_back(t);
    t = blank("jalr"); t.s1 = 32'h8000_0103; t.imm = 4; t.o2 = 1; t.nsel = 2; t.rsel = 1;
    t.mask = M_NPC | M_RW; t.e_npc = 32'h8000_0106; t.e_rw = 32'h8000_0004; vecs.push_back(t);
    t = blank("ecall_mepc"); t.pc = 32'h8000_0040; t.csr = 32'h8000_1000; t.nsel = 4; t.c2sel = 0;
    t.mask = M_NPC | M_C2; t.e_npc = 32'h8000_1000; t.e_c2 = 32'h8000_0040; vecs.push_back(t);
    t = blank("ecall_cause"); t.pc = 32'h8000_0040; t.csr = 32'h8000_1000; t.nsel = 4; t.c2sel = 1;
    t.mask = M_NPC | M_C2; t.e_npc = 32'h8000_1000; t.e_c2 = 32'd11; vecs.push_back(t);
    t = blank("csrrs"); t.csr = 32'h0F; t.s1 = 32'hF0; t.c1sel = 1; t.rsel = 5;
    t.mask = M_C1 | M_RW; t.e_c1 = 32'hFF; t.e_rw = 32'h0F; vecs.push_back(t);
    t = blank("csrrw"); t.csr = 32'h0F; t.s1 = 32'hF0; t.c1sel = 0; t.mask = M_C1; t.e_c1 = 32'hF0; vecs.push_back(t);
    t = blank("sra"); t.s1 = 32'h8000_0000; t.imm = 33; t.o2 = 1; t.op = 7; t.mask = M_ALU; t.e_alu = 32'hC000_0000; vecs.push_back(t);
    t = blank("srl"); t.s1 = 32'h8000_0000; t.imm = 33; t.o2 = 1; t.op = 6; t.mask = M_ALU; t.e_alu = 32'h4000_0000; vecs.push_back(t);
    t = blank("sll"); t.s1 = 1; t.s2 = 31; t.op = 5; t.mask = M_ALU; t.e_alu = 32'h8000_0000; vecs.push_back(t);
    t = blank("load"); t.rsel = 2; t.mem = 32'hFFFF_FF80; t.mask = M_RW; t.e_rw = 32'hFFFF_FF80; vecs.push_back(t);
    t = blank("pc_wrap"); t.pc = 32'hFFFF_FFFC; t.rsel = 1; t.mask = M_NPC | M_RW; t.e_npc = 0; t.e_rw = 0; vecs.push_back(t);
    t = blank("lui"); t.rsel = 3; t.imm = 32'h1234_5000; t.mask = M_RW; t.e_rw = 32'h1234_5000; vecs.push_back(t);
    t = blank("auipc_jal"); t.rsel = 4; t.nsel = 1; t.imm = 32'hFFFF_FFF0;
    t.mask = M_RW | M_NPC; t.e_rw = 32'h7FFF_FFF0; t.e_npc = 32'h7FFF_FFF0; vecs.push_back(t);
    t = blank("sub"); t.s1 = 3; t.s2 = 5; t.op = 1; t.nsel = 5; t.mask = M_ALU | M_NPC;
    t.e_alu = 32'hFFFF_FFFE; t.e_npc = 32'h8000_0004; vecs.push_back(t);
    t = blank("passb_zero"); t.s2 = 9; t.o2 = 3; t.op = 14; t.mask = M_ALU; t.e_alu = 0; vecs.push_back(t);
    t = blank("passb_csr"); t.csr = 32'hABCD; t.o2 = 2; t.op = 14; t.mask = M_ALU; t.e_alu = 32'hABCD; vecs.push_back(t);
    t = blank("and"); t.s1 = 32'hF0F0; t.s2 = 32'hFF00; t.op = 2; t.mask = M_ALU; t.e_alu = 32'hF000; vecs.push_back(t);
    t = blank("or");  t.s1 = 32'hF0F0; t.s2 = 32'hFF00; t.op = 3; t.mask = M_ALU; t.e_alu = 32'hFFF0; vecs.push_back(t);
    t = blank("xor"); t.s1 = 32'hF0F0; t.s2 = 32'hFF00; t.op = 4; t.mask = M_ALU; t.e_alu = 32'h0FF0; vecs.push_back(t);
    t = blank("sltu"); t.s1 = 1; t.s2 = 32'hFFFF_FFFF; t.op = 9; t.mask = M_ALU; t.e_alu = 1; vecs.push_back(t);
    t = blank("ge"); t.s1 = 1; t.s2 = 32'hFFFF_FFFF; t.op = 12; t.mask = M_ALU; t.e_alu = 1; vecs.push_back(t);
    t = blank("geu"); t.s1 = 1; t.s2 = 32'hFFFF_FFFF; t.op = 13; t.mask = M_ALU; t.e_alu = 0; vecs.push_back(t);
    t = blank("eq"); t.s1 = 7; t.s2 = 7; t.op = 10; t.mask = M_ALU; t.e_alu = 1; vecs.push_back(t);
    t = blank("ne"); t.s1 = 7; t.s2 = 7; t.op = 11; t.mask = M_ALU; t.e_alu = 0; vecs.push_back(t);
    t = blank("undef15"); t.s1 = 5; t.s2 = 6; t.op = 15; t.mask = M_ALU; t.e_alu = 0; vecs.push_back(t);
    t = blank("rsel6"); t.s1 = 5; t.s2 = 6; t.rsel = 6; t.mask = M_RW; t.e_rw = 0; vecs.push_back(t);
`ifdef YSYX_25010008_EXU_RV32M_EN
    t = blank("div0"); t.s1 = 7; t.s2 = 0; t.op = 20; t.mask = M_ALU; t.e_alu = 32'hFFFF_FFFF; vecs.push_back(t);
    t = blank("rem_ovf"); t.s1 = 32'h8000_0000; t.s2 = 32'hFFFF_FFFF; t.op = 22; t.mask = M_ALU; t.e_alu = 0; vecs.push_back(t);
    t = blank("div_ovf"); t.s1 = 32'h8000_0000; t.s2 = 32'hFFFF_FFFF; t.op = 20; t.mask = M_ALU; t.e_alu = 32'h8000_0000; vecs.push_back(t);
    t = blank("mulh"); t.s1 = 32'hFFFF_FFFF; t.s2 = 2; t.op = 17; t.mask = M_ALU; t.e_alu = 32'hFFFF_FFFF; vecs.push_back(t);
`else
    t = blank("mul_off"); t.s1 = 3; t.s2 = 4; t.op = 16; t.mask = M_ALU; t.e_alu = 0; vecs.push_back(t);
    t = blank("div_off"); t.s1 = 7; t.s2 = 0; t.op = 20; t.mask = M_ALU; t.e_alu = 0; vecs.push_back(t);
`endif

    // Power-on reset: npc held at the reset vector, done cleared
    t = blank("reset");
    t.v = 1'b1;
    drive(t);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset npc", npc, 32'h8000_0000);
    chk("reset done", {31'd0, done}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      t.v = ((i % 4) != 3);
      step(t);
    end

    // Isolated pulse: done for exactly one cycle
    t = blank("idle"); t.v = 1'b0; step(t); step(t);
    t = blank("pulse"); step(t);
    t = blank("idle"); t.v = 1'b0; step(t); step(t);
    // Back-to-back valid keeps done high
    t = blank("b2b"); step(t); step(t); step(t);

    // Reset asserted while an instruction is in flight
    @(posedge clk); #1;
    if (done_q.size() > 0) chk("done before mid reset", {31'd0, done}, {31'd0, done_q.pop_front()});
    t = blank("mid_reset"); t.s1 = 5; t.s2 = 6; t.nsel = 1; t.imm = 32'h100;
    drive(t);
    rst = 1'b0;
    done_q.push_back(1'b0);
    @(negedge clk);
    chk("mid_reset npc", npc, 32'h8000_0000);
    chk("mid_reset alu", alu_result, 32'd11);
    @(posedge clk); #1;
    chk("mid_reset done", {31'd0, done}, {31'd0, done_q.pop_front()});
    rst = 1'b1;
    t = blank("post_reset"); t.v = 1'b0; t.nsel = 1; t.imm = 32'h100;
    t.mask = M_NPC; t.e_npc = 32'h8000_0100;
    step(t);
    t = blank("idle"); t.v = 1'b0; step(t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
